// File: rtl/arb_defs.sv
// rtl/arb_defs.sv - shared state encodings, owner codes and burst default for sdram_port_arbiter
package arb_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_BURST,
    ST_WR_REQ,
    ST_RELEASE
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IC   = 2'd1;
  localparam logic [1:0] OWN_DC   = 2'd2;
  localparam logic [1:0] OWN_WR   = 2'd3;

  localparam int BURST_LEN_DEF = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - two-requester round-robin picker (ic vs dc) with its pointer register
module arb_rr_pick (
  input  logic clk,
  input  logic reset,
  input  logic ic_req,
  input  logic dc_req,
  input  logic advance,
  output logic pick_dc
);

  // ptr=0 favours ic, ptr=1 favours dc; it flips to the client not just granted
  logic ptr;

  assign pick_dc = dc_req & (~ic_req | ptr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~pick_dc;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares one SDRAM controller port between icache, dcache and write path
// Build option: ARB_ROUND_ROBIN_EN selects round-robin between ic/dc instead of dc-first priority.
module sdram_port_arbiter
  import arb_defs::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_fill,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_fill,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rw,
  output logic [15:0]       data_to_sdram,
  input  logic              sdram_fill,
  input  logic              sdram_wrack,
  output logic [1:0]        owner,
  output logic              err
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pick_dc;
  logic             in_rd;

`ifdef ARB_ROUND_ROBIN_EN
  logic rd_grant;
  assign rd_grant = (state == ST_IDLE) && !wr_req && (ic_req || dc_req);

  arb_rr_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .advance (rd_grant),
    .pick_dc (pick_dc)
  );
`else
  assign pick_dc = dc_req;
`endif

  // Fill routing is combinational so the owner sees data in the strobe cycle
  assign in_rd   = (state == ST_RD_REQ) || (state == ST_RD_BURST);
  assign ic_fill = sdram_fill & (owner == OWN_IC) & in_rd;
  assign dc_fill = sdram_fill & (owner == OWN_DC) & in_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sdram_req     <= 1'b0;
      sdram_rw      <= 1'b1;
      sdram_addr    <= '0;
      data_to_sdram <= '0;
      wr_ack        <= 1'b0;
      owner         <= OWN_NONE;
      err           <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sdram_fill || sdram_wrack) err <= 1'b1;
          if (wr_req) begin
            sdram_addr    <= wr_addr;
            data_to_sdram <= wr_data;
            sdram_rw      <= 1'b0;
            sdram_req     <= 1'b1;
            owner         <= OWN_WR;
            state         <= ST_WR_REQ;
          end else if (ic_req || dc_req) begin
            sdram_addr <= pick_dc ? dc_addr : ic_addr;
            sdram_rw   <= 1'b1;
            sdram_req  <= 1'b1;
            owner      <= pick_dc ? OWN_DC : OWN_IC;
            state      <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (sdram_wrack) err <= 1'b1;
          if (sdram_fill) begin
            sdram_req <= 1'b0;
            cnt       <= CNT_W'(1);
            state     <= ST_RD_BURST;
          end
        end
        ST_RD_BURST: begin
          if (sdram_wrack) err <= 1'b1;
          if (sdram_fill) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= ST_RELEASE;
          end
        end
        ST_WR_REQ: begin
          if (sdram_fill) err <= 1'b1;
          if (sdram_wrack) begin
            sdram_req <= 1'b0;
            wr_ack    <= 1'b1;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (sdram_fill || sdram_wrack) err <= 1'b1;
          owner <= OWN_NONE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter (BURST_LEN 8 and 4 instances)
module tb_sdram_port_arbiter;
  import arb_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        ic_req, dc_req, wr_req, sdram_fill, sdram_wrack;
  logic [31:0] ic_addr, dc_addr, wr_addr;
  logic [15:0] wr_data;
  logic        ic_fill, dc_fill, wr_ack, sdram_req, sdram_rw, err;
  logic [31:0] sdram_addr;
  logic [15:0] data_to_sdram;
  logic [1:0]  owner;

  logic        ic_req4, dc_req4, sdram_fill4;
  logic [31:0] ic_addr4, dc_addr4;
  logic        ic_fill4, dc_fill4, wr_ack4, sdram_req4, sdram_rw4, err4;
  logic [31:0] sdram_addr4;
  logic [15:0] data_to_sdram4;
  logic [1:0]  owner4;

  sdram_port_arbiter #(.BURST_LEN(8), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_fill(ic_fill),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_fill(dc_fill),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_rw(sdram_rw),
    .data_to_sdram(data_to_sdram), .sdram_fill(sdram_fill), .sdram_wrack(sdram_wrack),
    .owner(owner), .err(err)
  );

  sdram_port_arbiter #(.BURST_LEN(4), .ADDR_W(32)) u_dut4 (
    .clk(clk), .reset(reset),
    .ic_req(ic_req4), .ic_addr(ic_addr4), .ic_fill(ic_fill4),
    .dc_req(dc_req4), .dc_addr(dc_addr4), .dc_fill(dc_fill4),
    .wr_req(1'b0), .wr_addr(32'h0), .wr_data(16'h0), .wr_ack(wr_ack4),
    .sdram_req(sdram_req4), .sdram_addr(sdram_addr4), .sdram_rw(sdram_rw4),
    .data_to_sdram(data_to_sdram4), .sdram_fill(sdram_fill4), .sdram_wrack(1'b0),
    .owner(owner4), .err(err4)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;   // 0 grant, 1 fill, 2 write ack
    logic [1:0]  own;
    logic [31:0] addr;
    logic        rw;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] own, input logic [31:0] addr,
                      input logic rw, input logic [15:0] data);
    ev_t e;
    e.kind = kind; e.own = own; e.addr = addr; e.rw = rw; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_burst(input logic [1:0] own, input logic [31:0] addr, input int n);
    push(0, own, addr, 1'b1, 16'h0);
    for (int i = 0; i < n; i++) push(1, own, 32'h0, 1'b1, 16'h0);
  endtask

  task automatic observe(input int kind, input logic [1:0] own);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected actual=kind%0d/owner%0d required=no_event", kind, own);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind != 2) chk("sb_owner", {30'h0, own}, {30'h0, e.own});
      if (kind == 0) begin
        chk("sb_addr", sdram_addr, e.addr);
        chk("sb_rw", {31'h0, sdram_rw}, {31'h0, e.rw});
        if (!e.rw) chk("sb_data", {16'h0, data_to_sdram}, {16'h0, e.data});
      end
    end
  endtask

  logic prev_req = 1'b0;
  int   fill4_cnt = 0;

  always @(negedge clk) begin
    if (sdram_req && !prev_req) observe(0, owner);
    if (ic_fill) observe(1, OWN_IC);
    if (dc_fill) observe(1, OWN_DC);
    if (wr_ack) observe(2, OWN_NONE);
    prev_req = sdram_req;
    if (ic_fill4) fill4_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fills(input int n, input bit drop_ic, input bit drop_dc);
    for (int i = 0; i < n; i++) begin
      sdram_fill = 1'b1;
      tick();
      if (i == 0) begin
        if (drop_ic) ic_req = 1'b0;
        if (drop_dc) dc_req = 1'b0;
      end
    end
    sdram_fill = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk(name, {31'h0, sdram_req}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_own;
    ic_req = 0; dc_req = 0; wr_req = 0; sdram_fill = 0; sdram_wrack = 0;
    ic_addr = 0; dc_addr = 0; wr_addr = 0; wr_data = 0;
    ic_req4 = 0; dc_req4 = 0; sdram_fill4 = 0; ic_addr4 = 0; dc_addr4 = 32'h7800;
    tick(); tick();

    chk("rst_req", {31'h0, sdram_req}, 32'h0);
    chk("rst_rw", {31'h0, sdram_rw}, 32'h1);
    chk("rst_addr", sdram_addr, 32'h0);
    chk("rst_owner", {30'h0, owner}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b1;
    tick();

    // single icache burst, fills start three cycles after the grant
    push_burst(OWN_IC, 32'h1000, 8);
    ic_addr = 32'h1000; ic_req = 1'b1;
    chk("t1_req_before", {31'h0, sdram_req}, 32'h0);
    tick();
    chk("t1_grant_latency", {31'h0, sdram_req}, 32'h1);
    chk("t1_owner", {30'h0, owner}, 32'h1);
    tick(); tick();
    fills(8, 1'b1, 1'b0);
    chk("t1_req_dropped", {31'h0, sdram_req}, 32'h0);
    tick();
    chk("t1_owner_cleared", {30'h0, owner}, 32'h0);

    // write beats a simultaneous dcache read
    push(0, OWN_WR, 32'h2002, 1'b0, 16'hBEEF);
    push(2, OWN_WR, 32'h0, 1'b0, 16'h0);
    push_burst(OWN_DC, 32'h3000, 8);
    wr_addr = 32'h2002; wr_data = 16'hBEEF; dc_addr = 32'h3000;
    wr_req = 1'b1; dc_req = 1'b1;
    tick();
    chk("t2_wr_rw", {31'h0, sdram_rw}, 32'h0);
    chk("t2_wr_data", {16'h0, data_to_sdram}, 32'h0000BEEF);
    chk("t2_wr_owner", {30'h0, owner}, 32'h3);
    tick();
    sdram_wrack = 1'b1;
    chk("t2_ack_not_early", {31'h0, wr_ack}, 32'h0);
    tick();
    sdram_wrack = 1'b0; wr_req = 1'b0;
    chk("t2_wr_ack", {31'h0, wr_ack}, 32'h1);
    chk("t2_req_dropped", {31'h0, sdram_req}, 32'h0);
    tick();
    chk("t2_wr_ack_pulse", {31'h0, wr_ack}, 32'h0);
    chk("t2_gap", {31'h0, sdram_req}, 32'h0);
    tick();
    chk("t2_dc_grant", {31'h0, sdram_req}, 32'h1);
    chk("t2_dc_owner", {30'h0, owner}, 32'h2);
    fills(8, 1'b0, 1'b1);
    tick();

    // both caches requesting for four bursts
    ic_addr = 32'h4000; dc_addr = 32'h5000;
    for (int b = 0; b < 4; b++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = (b % 2 == 0) ? OWN_IC : OWN_DC;
`else
      exp_own = OWN_DC;
`endif
      push_burst(exp_own, (exp_own == OWN_IC) ? 32'h4000 : 32'h5000, 8);
    end
    ic_req = 1'b1; dc_req = 1'b1;
    for (int b = 0; b < 4; b++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = (b % 2 == 0) ? OWN_IC : OWN_DC;
`else
      exp_own = OWN_DC;
`endif
      wait_req("t3_grant");
      chk("t3_order", {30'h0, owner}, {30'h0, exp_own});
      fills(8, b == 3, b == 3);
    end
    tick();

    // stray fill while idle
    chk("t4_err_clear", {31'h0, err}, 32'h0);
    sdram_fill = 1'b1;
    tick();
    sdram_fill = 1'b0;
    chk("t4_err_set", {31'h0, err}, 32'h1);
    chk("t4_owner", {30'h0, owner}, 32'h0);
    chk("t4_no_req", {31'h0, sdram_req}, 32'h0);
    tick(); tick();
    chk("t4_err_sticky", {31'h0, err}, 32'h1);

    // reset mid-burst, then the controller finishes its burst
    push_burst(OWN_IC, 32'h6000, 3);
    ic_addr = 32'h6000; ic_req = 1'b1;
    tick();
    chk("t5_grant", {31'h0, sdram_req}, 32'h1);
    fills(3, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("t5_rst_req", {31'h0, sdram_req}, 32'h0);
    chk("t5_rst_rw", {31'h0, sdram_rw}, 32'h1);
    chk("t5_rst_addr", sdram_addr, 32'h0);
    chk("t5_rst_data", {16'h0, data_to_sdram}, 32'h0);
    chk("t5_rst_owner", {30'h0, owner}, 32'h0);
    chk("t5_rst_err", {31'h0, err}, 32'h0);
    chk("t5_rst_wr_ack", {31'h0, wr_ack}, 32'h0);
    tick();
    reset = 1'b1;
    fills(5, 1'b0, 1'b0);
    chk("t5_err_after", {31'h0, err}, 32'h1);

    // BURST_LEN=4 instance: release after four fills, next grant right after
    ic_addr4 = 32'h7000; ic_req4 = 1'b1;
    tick();
    chk("t6_grant", {31'h0, sdram_req4}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      sdram_fill4 = 1'b1;
      tick();
      if (i == 0) begin
        ic_req4 = 1'b0;
        dc_req4 = 1'b1;
      end
    end
    sdram_fill4 = 1'b0;
    chk("t6_fill_count", fill4_cnt, 32'd4);
    chk("t6_err", {31'h0, err4}, 32'h0);
    chk("t6_release_req", {31'h0, sdram_req4}, 32'h0);
    tick();
    chk("t6_idle_no_grant", {31'h0, sdram_req4}, 32'h0);
    tick();
    chk("t6_next_grant", {31'h0, sdram_req4}, 32'h1);
    chk("t6_next_owner", {30'h0, owner4}, 32'h2);
    chk("t6_next_addr", sdram_addr4, 32'h7800);
    dc_req4 = 1'b0;

    tick();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
